// File: rtl/data_upload.sv
// SPI responder that streams a file from shared SDRAM to the IO controller.
// sck/ss/sdi are oversampled in the clk domain; RAM words are fetched over a req/ack port.
module data_upload #(
  parameter logic [24:0] BASE_ADDR  = 25'hA0000,
  parameter logic [7:0]  CMD_RX_LEN = 8'h56,
  parameter logic [7:0]  CMD_RX_DAT = 8'h57
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  input  logic [24:0] size,
  output logic        uploading,
  output logic        rd_req,
  output logic [24:0] a,
  input  logic [15:0] q,
  input  logic        rd_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DAT  = 3'd3;
  localparam logic [2:0] S_IGN  = 3'd4;

  logic [2:0]  sck_sync_q;
  logic [1:0]  ss_sync_q;
  logic [1:0]  sdi_sync_q;

  logic [2:0]  state_q,   state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_q,      rx_d;
  logic [7:0]  tx_q,      tx_d;
  logic        sdo_q,     sdo_d;
  logic        upl_q,     upl_d;
  logic [24:0] size_q,    size_d;
  logic [25:0] idx_q,     idx_d;
  logic [15:0] buf_q,     buf_d;
  logic [23:0] buf_w_q,   buf_w_d;
  logic        buf_vld_q, buf_vld_d;
  logic [7:0]  hi_q,      hi_d;
  logic        hi_vld_q,  hi_vld_d;
  logic        pend_q,    pend_d;
  logic [23:0] req_w_q,   req_w_d;
  logic [23:0] fw_q,      fw_d;
  logic        rd_req_q,  rd_req_d;
  logic [24:0] a_q,       a_d;
  logic        drop_q,    drop_d;

  logic        rise, fall, ss_s, sdi_s;
  logic [7:0]  cmd_w;
  logic [7:0]  load_byte;
  logic [31:0] len_word;
  logic [25:0] n_w;
  logic [23:0] w_w, w_nx;
  logic        has_data, nxt_ok, w_busy, nx_busy;

  assign rise  = sck_sync_q[1] & ~sck_sync_q[2];
  assign fall  = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_s  = ss_sync_q[1];
  assign sdi_s = sdi_sync_q[1];
  assign cmd_w = {rx_q, sdi_s};

  assign len_word = {7'b0, size_q};
  // Index 0 of the data stream is the dummy byte; data byte n is idx-1.
  assign n_w      = idx_q - 26'd1;
  assign w_w      = n_w[24:1];
  assign w_nx     = w_w + 24'd1;
  assign has_data = n_w < {1'b0, size_q};
  assign nxt_ok   = ({1'b0, w_w, 1'b0} + 26'd2) < {1'b0, size_q};
  // A word counts as "on its way" if it is in flight (and kept) or queued to issue.
  assign w_busy   = (rd_req_q && !drop_q && fw_q == w_w) || (pend_q && req_w_q == w_w);
  assign nx_busy  = (rd_req_q && !drop_q && fw_q == w_nx) || (pend_q && req_w_q == w_nx);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    sdo_d     = sdo_q;
    upl_d     = upl_q;
    size_d    = size_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    buf_w_d   = buf_w_q;
    buf_vld_d = buf_vld_q;
    hi_d      = hi_q;
    hi_vld_d  = hi_vld_q;
    pend_d    = pend_q;
    req_w_d   = req_w_q;
    fw_d      = fw_q;
    rd_req_d  = rd_req_q;
    a_d       = a_q;
    drop_d    = drop_q;
    load_byte = 8'h00;

    if (!rd_req_q && pend_q) begin
      rd_req_d = 1'b1;
      a_d      = BASE_ADDR + {req_w_q, 1'b0};
      fw_d     = req_w_q;
      pend_d   = 1'b0;
    end

    if (state_q == S_IDLE) begin
      sdo_d     = 1'b0;
      tx_d      = 8'h00;
      bit_cnt_d = 3'd0;
      if (!ss_s) state_d = S_CMD;
    end else if (ss_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      upl_d     = 1'b0;
      sdo_d     = 1'b0;
      tx_d      = 8'h00;
      pend_d    = 1'b0;
      buf_vld_d = 1'b0;
      hi_vld_d  = 1'b0;
      drop_d    = rd_req_d;
    end else begin
      if (rise) begin
        rx_d      = {rx_q[5:0], sdi_s};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7 && state_q == S_CMD) begin
          size_d = size;
          idx_d  = 26'd0;
          if (cmd_w == CMD_RX_LEN) begin
            state_d = S_LEN;
          end else if (cmd_w == CMD_RX_DAT) begin
            state_d   = S_DAT;
            upl_d     = 1'b1;
            buf_vld_d = 1'b0;
            hi_vld_d  = 1'b0;
            if (size != 25'd0) begin
              pend_d  = 1'b1;
              req_w_d = 24'd0;
            end
          end else begin
            state_d = S_IGN;
          end
        end
      end

      if (fall) begin
        if (bit_cnt_q == 3'd0 && state_q != S_CMD) begin
          if (state_q == S_LEN && idx_q < 26'd4) begin
            case (idx_q[1:0])
              2'd0:    load_byte = len_word[31:24];
              2'd1:    load_byte = len_word[23:16];
              2'd2:    load_byte = len_word[15:8];
              default: load_byte = len_word[7:0];
            endcase
          end else if (state_q == S_DAT) begin
            if (idx_q == 26'd0) begin
              load_byte = 8'hFF;
            end else if (has_data && !n_w[0]) begin
              if (buf_vld_q && buf_w_q == w_w) begin
                load_byte = buf_q[7:0];
                hi_d      = buf_q[15:8];
                hi_vld_d  = 1'b1;
                buf_vld_d = 1'b0;
                if (nxt_ok) begin
                  pend_d  = 1'b1;
                  req_w_d = w_nx;
                end
              end else begin
                // Underrun: anything still buffered is an older word.
                buf_vld_d = 1'b0;
                if (!w_busy) begin
                  pend_d  = 1'b1;
                  req_w_d = w_w;
                end
              end
            end else if (has_data) begin
              if (hi_vld_q) begin
                load_byte = hi_q;
                hi_vld_d  = 1'b0;
              end else if (buf_vld_q && buf_w_q == w_w) begin
                load_byte = buf_q[15:8];
                buf_vld_d = 1'b0;
                if (nxt_ok) begin
                  pend_d  = 1'b1;
                  req_w_d = w_nx;
                end
              end else if (nxt_ok && !nx_busy) begin
                pend_d  = 1'b1;
                req_w_d = w_nx;
              end
            end
          end
          sdo_d = load_byte[7];
          tx_d  = {load_byte[6:0], 1'b0};
          idx_d = idx_q + 26'd1;
        end else begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
    end

    // Data returned for an aborted transaction is thrown away.
    if (rd_req_q && rd_ack) begin
      rd_req_d = 1'b0;
      drop_d   = 1'b0;
      if (!drop_q) begin
        buf_d     = q;
        buf_w_d   = fw_q;
        buf_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_sync_q <= 3'b000;
      ss_sync_q  <= 2'b11;
      sdi_sync_q <= 2'b00;
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      rx_q       <= 7'd0;
      tx_q       <= 8'd0;
      sdo_q      <= 1'b0;
      upl_q      <= 1'b0;
      size_q     <= 25'd0;
      idx_q      <= 26'd0;
      buf_q      <= 16'd0;
      buf_w_q    <= 24'd0;
      buf_vld_q  <= 1'b0;
      hi_q       <= 8'd0;
      hi_vld_q   <= 1'b0;
      pend_q     <= 1'b0;
      req_w_q    <= 24'd0;
      fw_q       <= 24'd0;
      rd_req_q   <= 1'b0;
      a_q        <= BASE_ADDR;
      drop_q     <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[1:0], sck};
      ss_sync_q  <= {ss_sync_q[0], ss};
      sdi_sync_q <= {sdi_sync_q[0], sdi};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      sdo_q      <= sdo_d;
      upl_q      <= upl_d;
      size_q     <= size_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      buf_w_q    <= buf_w_d;
      buf_vld_q  <= buf_vld_d;
      hi_q       <= hi_d;
      hi_vld_q   <= hi_vld_d;
      pend_q     <= pend_d;
      req_w_q    <= req_w_d;
      fw_q       <= fw_d;
      rd_req_q   <= rd_req_d;
      a_q        <= a_d;
      drop_q     <= drop_d;
    end
  end

  assign sdo       = sdo_q;
  assign uploading = upl_q;
  assign rd_req    = rd_req_q;
  assign a         = a_q;

endmodule

// File: tb/tb_data_upload.sv
// Directed bench for data_upload: SPI master, RAM responder and a byte scoreboard.
module tb_data_upload;

  localparam int HALF = 8;  // sck = clk/16

  logic        clk = 1'b0;
  logic        reset_n, sck, ss, sdi, sdo, uploading, rd_req, rd_ack;
  logic [24:0] size, a;
  logic [15:0] q;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q[$];
  logic [24:0] fetch_log[$];
  int          fetch_cnt = 0;
  int          ack_cnt = 0;
  logic [15:0] mem [0:7];
  logic [24:0] slow_addr;
  int          slow_dly = 0;
  bit          slow_armed = 0;
  int          ram_dly;
  logic [24:0] ram_off;
  int          base_cnt, base_ack;
  logic [7:0]  rx_byte;
  logic [24:0] f0, f1;

  always #5 clk = ~clk;

  data_upload dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sck       (sck),
    .ss        (ss),
    .sdi       (sdi),
    .sdo       (sdo),
    .size      (size),
    .uploading (uploading),
    .rd_req    (rd_req),
    .a         (a),
    .q         (q),
    .rd_ack    (rd_ack)
  );

  // RAM responder: ack after a per-request delay, data valid with the ack pulse.
  initial begin
    rd_ack = 1'b0;
    q      = 16'h0000;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        fetch_log.push_back(a);
        fetch_cnt++;
        ram_dly = 3;
        if (slow_armed && a == slow_addr) begin
          ram_dly    = slow_dly;
          slow_armed = 0;
        end
        repeat (ram_dly) @(negedge clk);
        ram_off = a - 25'hA0000;
        q       = mem[ram_off[3:1]];
        rd_ack  = 1'b1;
        ack_cnt++;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sdi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = sdo;
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic xfer_check(input logic [7:0] tx, input string tag);
    logic [7:0] e;
    spi_byte(tx, rx_byte);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk(tag, {24'd0, rx_byte}, {24'd0, e});
    $display("byte %s: sent %02h received %02h", tag, tx, rx_byte);
  endtask

  task automatic ss_start();
    ss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic ss_stop();
    repeat (HALF) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; ss = 1'b1; sck = 1'b0; sdi = 1'b0; size = 25'd0;
    mem[0] = 16'hBBAA; mem[1] = 16'hDDCC; mem[2] = 16'h2211; mem[3] = 16'h4433;
    mem[4] = 16'h0; mem[5] = 16'h0; mem[6] = 16'h0; mem[7] = 16'h0;
    slow_addr = 25'h0;
    repeat (3) @(negedge clk);
    chk("reset_sdo", {31'd0, sdo}, 32'd0);
    chk("reset_uploading", {31'd0, uploading}, 32'd0);
    chk("reset_rd_req", {31'd0, rd_req}, 32'd0);
    chk("reset_a", {7'd0, a}, 32'h000A0000);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Length read
    size = 25'h0012345; base_cnt = fetch_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    exp_q.push_back(8'h45); exp_q.push_back(8'h00);
    ss_start();
    xfer_check(8'h56, "len_cmd");
    for (int i = 0; i < 5; i++) xfer_check(8'h00, "len_data");
    ss_stop();
    chk("len_no_fetch", fetch_cnt - base_cnt, 32'd0);

    // Length with bit 24 set
    size = 25'h1ABCDEF;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01); exp_q.push_back(8'hAB); exp_q.push_back(8'hCD); exp_q.push_back(8'hEF);
    ss_start();
    xfer_check(8'h56, "len2_cmd");
    for (int i = 0; i < 4; i++) xfer_check(8'h00, "len2_data");
    ss_stop();

    // Data stream with fast RAM
    size = 25'd4; fetch_log.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD); exp_q.push_back(8'h00);
    ss_start();
    xfer_check(8'h57, "dat_cmd");
    chk("dat_uploading_on", {31'd0, uploading}, 32'd1);
    for (int i = 0; i < 6; i++) xfer_check(8'h00, "dat_data");
    chk("dat_uploading_held", {31'd0, uploading}, 32'd1);
    ss_stop();
    chk("dat_uploading_off", {31'd0, uploading}, 32'd0);
    chk("dat_fetch_count", fetch_log.size(), 32'd2);
    f0 = (fetch_log.size() > 0) ? fetch_log[0] : 25'h1FFFFFF;
    f1 = (fetch_log.size() > 1) ? fetch_log[1] : 25'h1FFFFFF;
    chk("dat_fetch_addr0", {7'd0, f0}, 32'h000A0000);
    chk("dat_fetch_addr1", {7'd0, f1}, 32'h000A0002);

    // Slow first fetch: data byte 0 underruns, stream resumes at index 1
    size = 25'd4; fetch_log.delete();
    slow_addr = 25'hA0000; slow_dly = 200; slow_armed = 1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD); exp_q.push_back(8'h00);
    ss_start();
    xfer_check(8'h57, "slow_cmd");
    for (int i = 0; i < 6; i++) xfer_check(8'h00, "slow_data");
    ss_stop();
    chk("slow_fetch_count", fetch_log.size(), 32'd2);

    // Empty file: dummy byte then zeros, no fetches
    size = 25'd0; base_cnt = fetch_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    ss_start();
    xfer_check(8'h57, "empty_cmd");
    for (int i = 0; i < 3; i++) xfer_check(8'h00, "empty_data");
    ss_stop();
    chk("empty_no_fetch", fetch_cnt - base_cnt, 32'd0);

    // Abort mid-byte while the third word fetch is outstanding
    size = 25'd8;
    slow_addr = 25'hA0004; slow_dly = 300; slow_armed = 1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    ss_start();
    xfer_check(8'h57, "abort_cmd");
    for (int i = 0; i < 3; i++) xfer_check(8'h00, "abort_data");
    for (int i = 0; i < 3; i++) begin
      sdi = 1'b0;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
    repeat (HALF / 2) @(negedge clk);
    chk("abort_rd_req_before", {31'd0, rd_req}, 32'd1);
    chk("abort_addr", {7'd0, a}, 32'h000A0004);
    base_ack = ack_cnt;
    ss = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_uploading_off", {31'd0, uploading}, 32'd0);
    chk("abort_rd_req_held", {31'd0, rd_req}, 32'd1);
    for (int i = 0; i < 1000 && rd_req === 1'b1; i++) @(negedge clk);
    chk("abort_rd_req_released", {31'd0, rd_req}, 32'd0);
    chk("abort_acked", ack_cnt - base_ack, 32'd1);
    repeat (8) @(negedge clk);

    // Normal transaction after the abort
    size = 25'h0000102; base_cnt = fetch_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    ss_start();
    xfer_check(8'h56, "post_abort_cmd");
    for (int i = 0; i < 4; i++) xfer_check(8'h00, "post_abort_data");
    ss_stop();

    // Unknown command
    exp_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
    ss_start();
    xfer_check(8'h12, "unk_cmd");
    for (int i = 0; i < 4; i++) xfer_check(8'hA5, "unk_data");
    chk("unk_uploading", {31'd0, uploading}, 32'd0);
    ss_stop();
    chk("unk_no_fetch", fetch_cnt - base_cnt, 32'd0);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
